// File: rtl/step_pkg.sv
// Shared types and defaults for the step pulse counter: FSM encoding,
// default filter/timeout constants and a saturating increment helper.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } step_state_e;

  localparam int unsigned FILTER_LEN_DEF     = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;
  localparam int unsigned POS_W              = 32;
  localparam int unsigned CNT_W              = 32;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/step_glitch_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter: the output
// follows the input only after FILTER_LEN consecutive identical samples.
module step_glitch_filter
  import step_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o
);

  localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       filt_q;
  logic       filt_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // The run counter tracks how long the synchronized sample has disagreed
  // with the filtered value; any agreeing sample restarts the run.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout_o = filt_q;

endmodule

// File: rtl/step_pulse_counter.sv
// Step/direction decoder: filters the inputs, accumulates a signed position,
// measures the step period, flags stalls and compares against an armed target.
module step_pulse_counter
  import step_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    clear,
  input  logic                    arm,
  input  logic signed [POS_W-1:0] target,
  output logic signed [POS_W-1:0] position,
  output logic                    step_evt,
  output logic [CNT_W-1:0]        period,
  output logic                    period_valid,
  output logic                    at_target,
  output logic                    stalled
);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

  logic step_f;
  logic dir_f;
  logic step_f_q;
  logic step_acc;

  step_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_step_filt (
    .clk    (clk),
    .rst    (rst),
    .din_i  (step_in),
    .dout_o (step_f)
  );

  step_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filt (
    .clk    (clk),
    .rst    (rst),
    .din_i  (dir_in),
    .dout_o (dir_f)
  );

  assign step_acc = step_f & ~step_f_q;

  logic signed [POS_W-1:0] position_q, position_d;
  logic signed [POS_W-1:0] target_q, target_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        period_q, period_d;
  logic                    period_valid_q, period_valid_d;
  logic                    seen_q, seen_d;
  logic                    armed_q, armed_d;
  logic                    step_evt_q, step_evt_d;
  logic                    at_target_q, at_target_d;
  step_state_e             state_q;
  logic                    stalled_q;

  // Clear outranks everything, including a step accepted in the same cycle.
  always_comb begin
    position_d     = position_q;
    target_d       = target_q;
    cnt_d          = sat_inc(cnt_q);
    period_d       = period_q;
    period_valid_d = period_valid_q;
    seen_d         = seen_q;
    armed_d        = armed_q;
    step_evt_d     = 1'b0;
    at_target_d    = (position_q == target_q) && armed_q;
    if (arm) begin
      target_d = target;
      armed_d  = 1'b1;
    end
    if (clear) begin
      position_d     = '0;
      cnt_d          = '0;
      period_d       = '0;
      period_valid_d = 1'b0;
      seen_d         = 1'b0;
      armed_d        = 1'b0;
      at_target_d    = 1'b0;
    end else if (step_acc) begin
      position_d = dir_f ? position_q + 32'sd1 : position_q - 32'sd1;
      step_evt_d = 1'b1;
      cnt_d      = '0;
      seen_d     = 1'b1;
      if (seen_q) begin
        period_d       = sat_inc(cnt_q);
        period_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_f_q       <= 1'b0;
      position_q     <= '0;
      target_q       <= '0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      seen_q         <= 1'b0;
      armed_q        <= 1'b0;
      step_evt_q     <= 1'b0;
      at_target_q    <= 1'b0;
    end else begin
      step_f_q       <= step_f;
      position_q     <= position_d;
      target_q       <= target_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      seen_q         <= seen_d;
      armed_q        <= armed_d;
      step_evt_q     <= step_evt_d;
      at_target_q    <= at_target_d;
    end
  end

  // A step arriving in the same cycle as the timeout keeps the FSM running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stalled_q <= 1'b0;
    end else if (clear) begin
      state_q   <= ST_IDLE;
      stalled_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (step_acc) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!step_acc && (cnt_q >= TIMEOUT)) begin
            state_q   <= ST_STALL;
            stalled_q <= 1'b1;
          end
        end
        ST_STALL: begin
          if (step_acc) begin
            state_q   <= ST_RUN;
            stalled_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          stalled_q <= 1'b0;
        end
      endcase
    end
  end

  assign position     = position_q;
  assign step_evt     = step_evt_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign at_target    = at_target_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_step_pulse_counter.sv
// Bench for step_pulse_counter: pulse-width vector table plus hand sequences,
// with a scoreboard matching each step_evt against its expected cycle and position.
module tb_step_pulse_counter;
  import step_pkg::*;

  localparam int unsigned FL = 4;
  localparam int unsigned TO = 50;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               step_in = 1'b0;
  logic               dir_in = 1'b0;
  logic               clear = 1'b0;
  logic               arm = 1'b0;
  logic signed [31:0] target = '0;
  logic signed [31:0] position;
  logic               step_evt;
  logic [31:0]        period;
  logic               period_valid;
  logic               at_target;
  logic               stalled;

  step_pulse_counter #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .step_in      (step_in),
    .dir_in       (dir_in),
    .clear        (clear),
    .arm          (arm),
    .target       (target),
    .position     (position),
    .step_evt     (step_evt),
    .period       (period),
    .period_valid (period_valid),
    .at_target    (at_target),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int evt_cnt = 0;
  logic signed [31:0] model_pos = '0;

  typedef struct {
    int unsigned cyc;
    logic [31:0] pos;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    int          hi;
    bit          d;
    bit          acc;
    logic [31:0] pos;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Called at the negedge where step_in rises; the step lands FL+3 edges later.
  task automatic push(input bit d);
    exp_t e;
    model_pos = d ? model_pos + 32'sd1 : model_pos - 32'sd1;
    e.cyc = cyc + FL + 3;
    e.pos = model_pos;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && step_evt) begin
      exp_t e;
      evt_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_evt", 32'(step_evt), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_pos", position, e.pos);
      end
    end
  end

  task automatic pulse(input int hi, input bit d, input bit acc);
    dir_in = d;
    repeat (8) @(negedge clk);
    step_in = 1'b1;
    if (acc) push(d);
    repeat (hi) @(negedge clk);
    step_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Returns at the negedge where step_evt is seen (or after a bounded wait).
  task automatic step_until_evt(input bit d);
    bit seen;
    dir_in = d;
    repeat (8) @(negedge clk);
    step_in = 1'b1;
    push(d);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 4) step_in = 1'b0;
      if (step_evt) seen = 1'b1;
    end
    step_in = 1'b0;
    if (!seen) chk("evt_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_pos = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    bit got;

    vecs[0] = '{hi: 4,  d: 1'b1, acc: 1'b1, pos: 32'd1};
    vecs[1] = '{hi: 3,  d: 1'b1, acc: 1'b0, pos: 32'd1};
    vecs[2] = '{hi: 6,  d: 1'b1, acc: 1'b1, pos: 32'd2};
    vecs[3] = '{hi: 1,  d: 1'b1, acc: 1'b0, pos: 32'd2};
    vecs[4] = '{hi: 4,  d: 1'b0, acc: 1'b1, pos: 32'd1};
    vecs[5] = '{hi: 2,  d: 1'b0, acc: 1'b0, pos: 32'd1};
    vecs[6] = '{hi: 5,  d: 1'b0, acc: 1'b1, pos: 32'd0};
    vecs[7] = '{hi: 10, d: 1'b0, acc: 1'b1, pos: 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_position", position, 32'd0);
    chk("rst_step_evt", 32'(step_evt), 32'd0);
    chk("rst_period", period, 32'd0);
    chk("rst_period_valid", 32'(period_valid), 32'd0);
    chk("rst_at_target", 32'(at_target), 32'd0);
    chk("rst_stalled", 32'(stalled), 32'd0);

    for (int v = 0; v < 8; v++) begin
      pulse(vecs[v].hi, vecs[v].d, vecs[v].acc);
      chk($sformatf("vec%0d_position", v), position, vecs[v].pos);
    end

    // Five forward steps exactly 100 cycles apart.
    do_clear();
    chk("clr_position", position, 32'd0);
    chk("clr_period", period, 32'd0);
    chk("clr_period_valid", 32'(period_valid), 32'd0);
    dir_in = 1'b1;
    repeat (10) @(negedge clk);
    t0 = evt_cnt;
    for (int s = 0; s < 5; s++) begin
      step_in = 1'b1;
      push(1'b1);
      repeat (4) @(negedge clk);
      step_in = 1'b0;
      repeat (4) @(negedge clk);
      chk($sformatf("p100_valid%0d", s), 32'(period_valid), (s == 0) ? 32'd0 : 32'd1);
      if (s > 0) chk($sformatf("p100_period%0d", s), period, 32'd100);
      repeat (92) @(negedge clk);
    end
    chk("p100_position", position, 32'd5);
    chk("p100_evt_count", 32'(evt_cnt - t0), 32'd5);

    // Stall after TO quiet cycles, recovery on the next step.
    do_clear();
    chk("idle_stalled", 32'(stalled), 32'd0);
    step_until_evt(1'b1);
    repeat (40) @(negedge clk);
    chk("stall_early", 32'(stalled), 32'd0);
    got = 1'b0;
    for (int i = 41; i < 70 && !got; i++) begin
      @(negedge clk);
      if (stalled) begin
        got = 1'b1;
        chk("stall_delay_in_window", 32'((i >= 49) && (i <= 52)), 32'd1);
      end
    end
    chk("stall_set", 32'(got), 32'd1);
    step_until_evt(1'b1);
    chk("stall_cleared", 32'(stalled), 32'd0);
    chk("state_run", 32'(dut.state_q), 32'(ST_RUN));
    repeat (8) @(negedge clk);

    // Wrap around the signed 32-bit boundary in both directions.
    force dut.position_q = 32'sh7FFF_FFFF;
    @(negedge clk);
    release dut.position_q;
    model_pos = 32'sh7FFF_FFFF;
    step_until_evt(1'b1);
    repeat (8) @(negedge clk);
    chk("wrap_fwd", position, 32'h8000_0000);
    step_until_evt(1'b0);
    repeat (8) @(negedge clk);
    chk("wrap_rev", position, 32'h7FFF_FFFF);

    // Armed target of -3 reached by three reverse steps.
    do_clear();
    target = -32'sd3;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    target = '0;
    @(negedge clk);
    chk("arm_not_yet", 32'(at_target), 32'd0);
    for (int s = 0; s < 3; s++) begin
      step_until_evt(1'b0);
      if (s < 2) repeat (8) @(negedge clk);
    end
    chk("tgt_same_cycle", 32'(at_target), 32'd0);
    @(negedge clk);
    chk("tgt_hit", 32'(at_target), 32'd1);
    chk("tgt_position", position, 32'hFFFF_FFFD);
    repeat (8) @(negedge clk);
    step_until_evt(1'b0);
    @(negedge clk);
    chk("tgt_left", 32'(at_target), 32'd0);
    repeat (8) @(negedge clk);

    // Clear landing on the very edge that would accept a step.
    dir_in = 1'b1;
    repeat (8) @(negedge clk);
    step_in = 1'b1;
    repeat (4) @(negedge clk);
    step_in = 1'b0;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_pos = '0;
    chk("clrevt_no_strobe", 32'(step_evt), 32'd0);
    chk("clrevt_position", position, 32'd0);
    chk("clrevt_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("clrevt_stalled", 32'(stalled), 32'd0);
    repeat (10) @(negedge clk);
    chk("clrevt_quiet_after", position, 32'd0);

    // Reset in the middle of filtering a step, after building some state.
    step_until_evt(1'b1);
    repeat (8) @(negedge clk);
    step_until_evt(1'b1);
    repeat (8) @(negedge clk);
    chk("pre_rst_valid", 32'(period_valid), 32'd1);
    step_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_pos = '0;
    repeat (15) @(negedge clk);
    chk("mid_rst_position", position, 32'd0);
    chk("mid_rst_step_evt", 32'(step_evt), 32'd0);
    chk("mid_rst_period", period, 32'd0);
    chk("mid_rst_period_valid", 32'(period_valid), 32'd0);
    chk("mid_rst_at_target", 32'(at_target), 32'd0);
    chk("mid_rst_stalled", 32'(stalled), 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_pulse_counter.md
STEP_PULSE_COUNTER -- requirements
Module: step_pulse_counter

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning consecutive equal samples required before a filtered input changes (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning idle cycles after the last step before stall is flagged (range 1..2^32-1).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port step_in, input, 1, meaning asynchronous step pulse line; each rising edge is one step.
REQ-006 SHALL have port dir_in, input, 1, meaning asynchronous direction: 1 = forward, 0 = reverse.
REQ-007 SHALL have port clear, input, 1, meaning one-cycle synchronous request to zero position and return to IDLE.
REQ-008 SHALL have port arm, input, 1, meaning one-cycle strobe that latches target and enables comparison.
REQ-009 SHALL have port target, input, 32, meaning signed step position to compare against.
REQ-010 SHALL have port position, output, 32, meaning signed accumulated step count.
REQ-011 SHALL have port step_evt, output, 1, meaning one-cycle strobe per accepted step.
REQ-012 SHALL have port period, output, 32, meaning clk cycles between the last two accepted steps.
REQ-013 SHALL have port period_valid, output, 1, meaning period holds a genuine measurement.
REQ-014 SHALL have port at_target, output, 1, meaning position equals the latched target while armed.
REQ-015 SHALL have port stalled, output, 1, meaning no step for TIMEOUT_CYCLES while running.

Function
REQ-016 SHALL pass step_in and dir_in through 2-flop synchronizers, then a glitch filter; the filtered value updates only after FILTER_LEN consecutive identical synchronized samples.
REQ-017 SHALL accept a step on each 0->1 transition of filtered step; the latency from step_in rising (setup met) to step_evt high SHALL be exactly FILTER_LEN+3 clk edges, constant.
REQ-018 SHALL, on an accepted step, add +1 to position if filtered dir is 1, else -1, using the dir value filtered in the same cycle; wrap 0x7FFFFFFF+1 -> 0x80000000 and 0x80000000-1 -> 0x7FFFFFFF with no saturation.
REQ-019 SHALL run a 32-bit cycle counter that saturates at 0xFFFFFFFF, is zeroed on each accepted step, and loads period with counter+1 (saturating) on each accepted step except the first after reset or clear.
REQ-020 SHALL set period_valid on the second and later accepted steps after reset or clear.
REQ-021 SHALL implement FSM IDLE -> RUN on an accepted step; RUN -> STALL when the cycle counter reaches TIMEOUT_CYCLES; STALL -> RUN on an accepted step; any state -> IDLE on clear.
REQ-022 SHALL drive stalled high only in STALL.
REQ-023 SHALL, on arm, latch target into target_q and set armed; at_target is registered as (position == target_q) && armed, one cycle after position or target_q changes.
REQ-024 SHALL give clear precedence: clear coinciding with an accepted step zeroes position, discards the step, and suppresses step_evt; clear also zeroes period, period_valid and armed.
REQ-025 SHALL, for arm coinciding with an accepted step, compare against the updated position.

Reset
REQ-026 SHALL on rst force position=0, period=0, period_valid=0, step_evt=0, at_target=0, stalled=0, armed=0, target_q=0, FSM=IDLE, counter=0, and all synchronizer and filter state=0.
REQ-027 SHALL treat rst asserted mid-step as a complete reset, with no partial step counted after release.

Structure
REQ-028 SHALL place the FSM state type (IDLE/RUN/STALL) and the default FILTER_LEN/TIMEOUT_CYCLES constants in the shared package step_pkg.
REQ-029 SHALL implement the synchronizer plus filter as sub-module step_glitch_filter, instantiated once for step_in and once for dir_in.

Verification
REQ-030 SHALL verify: dir_in=1, 5 clean steps 100 cycles apart -> position=5, five step_evt strobes, period=100, period_valid=1 after the second step.
REQ-031 SHALL verify: with FILTER_LEN=4, step_in high for 3 cycles -> no step_evt and position unchanged; high for 4 cycles -> exactly one step_evt.
REQ-032 SHALL verify: position preloaded to 0x7FFFFFFF via steps or force, one forward step -> 0x80000000; one reverse step -> 0x7FFFFFFF.
REQ-033 SHALL verify: with TIMEOUT_CYCLES=50, one step then quiet -> stalled=1 after 50 cycles; next step -> stalled=0, FSM=RUN.
REQ-034 SHALL verify: arm with target=-3, dir_in=0, 3 steps -> at_target=1 one cycle after the third position update; a fourth step -> at_target=0.
REQ-035 SHALL verify: clear coincident with step_evt -> position=0, no strobe, IDLE; rst pulsed mid-filter -> all outputs 0.
